multdiv_stall_ctrl: RTL and testbench

- Sequences the shared multi-cycle multiplier/divider unit for the 5-stage pipeline.
- Detects mul/div in the DX stage, freezes PC/FD/DX, issues a one-cycle start pulse with held operands, and waits for ready or timeout.
- Hands result, destination register and exception status to the XM latch.
- Sits beside the ALU in the execute stage.

---
 rtl/multdiv_stall_ctrl.sv | 114 +++++++++++
 tb/tb_multdiv_stall_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_stall_ctrl.sv
// multdiv_stall_ctrl: sequences the shared multi-cycle mul/div unit from the execute stage,
// freezing PC/FD/DX while it runs and handing the result to the XM latch.
module multdiv_stall_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dx_ir,
    input  logic        dx_valid,
    input  logic        flush,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_result_rdy,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic [31:0] md_operand_a,
    output logic [31:0] md_operand_b,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  dest_reg,
    output logic        exception
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic div_q, div_d;
    logic [4:0] rd_q, rd_d, dest_q, dest_d;
    logic [31:0] opa_q, opa_d, opb_q, opb_d, result_q, result_d;
    logic exc_q, exc_d;
    logic is_md, start, finish, wb_exc, unused_ir;
    assign unused_ir = ^{dx_ir[21:7], dx_ir[1:0]};
    assign is_md = dx_valid && dx_ir[31:27] == 5'b00000
                   && (dx_ir[6:2] == 5'b00110 || dx_ir[6:2] == 5'b00111);
    assign start = state_q == IDLE && is_md && !flush;
    // flush beats ready; ready beats timeout
    assign finish = state_q == WAIT && !flush && (md_result_rdy || cnt_q == CNT_LAST);
    assign wb_exc = md_result_rdy ? md_exception : 1'b1;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        rd_d     = rd_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        dest_d   = dest_q;
        exc_d    = exc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    div_d   = dx_ir[2];
                    rd_d    = dx_ir[26:22];
                    opa_d   = operand_a;
                    opb_d   = operand_b;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = flush ? IDLE : WAIT;
            end
            WAIT: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = flush ? IDLE : (finish ? DONE : WAIT);
                if (finish) begin
                    exc_d    = wb_exc;
                    dest_d   = wb_exc ? 5'd30 : rd_q;
                    result_d = wb_exc ? {29'd0, 2'b10, div_q} : md_result;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            rd_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            dest_q   <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            rd_q     <= rd_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            dest_q   <= dest_d;
            exc_q    <= exc_d;
        end
    end
    // gated by reset so an asserted reset drops the freeze immediately
    assign stall        = reset && (start || state_q == ISSUE || state_q == WAIT);
    assign busy         = state_q != IDLE;
    assign done         = state_q == DONE;
    assign md_ctrl_mult = state_q == ISSUE && !div_q;
    assign md_ctrl_div  = state_q == ISSUE && div_q;
    assign md_operand_a = opa_q;
    assign md_operand_b = opb_q;
    assign result       = result_q;
    assign dest_reg     = dest_q;
    assign exception    = exc_q;
endmodule

// File: tb/tb_multdiv_stall_ctrl.sv
// tb_multdiv_stall_ctrl: directed scenarios checked every cycle against an elapsed-cycle model,
// plus literal expectations on latency, pulse counts and writeback values.
module tb_multdiv_stall_ctrl;
    localparam int T = 8;
    logic clock = 0, reset = 0;
    logic [31:0] dx_ir = 0, operand_a = 0, operand_b = 0, md_result = 0;
    logic dx_valid = 0, flush = 0, md_exception = 0, md_result_rdy = 0;
    logic md_ctrl_mult, md_ctrl_div, stall, busy, done, exception;
    logic [31:0] md_operand_a, md_operand_b, result;
    logic [4:0] dest_reg;
    int npass = 0, ntot = 0, cyc = 0;
    bit chk_en = 0;

    multdiv_stall_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .dx_ir(dx_ir), .dx_valid(dx_valid), .flush(flush),
        .operand_a(operand_a), .operand_b(operand_b), .md_result(md_result),
        .md_exception(md_exception), .md_result_rdy(md_result_rdy),
        .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
        .md_operand_a(md_operand_a), .md_operand_b(md_operand_b),
        .stall(stall), .busy(busy), .done(done), .result(result),
        .dest_reg(dest_reg), .exception(exception)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic md_f(input logic [31:0] ir, input logic v);
        return v && ir[31:27] == 5'd0 && (ir[6:2] == 5'b00110 || ir[6:2] == 5'b00111);
    endfunction

    function automatic logic [31:0] ins(input logic [4:0] alu, input logic [4:0] rd);
        return {5'd0, rd, 5'd1, 5'd2, 5'd0, alu, 2'b00};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, got, exp);
    endtask

    // model: age = cycles since the op left IDLE (-1 when idle); fin = age at which done shows
    int age = -1, fin = 0;
    logic mdiv = 0;
    logic [4:0] mrd = 0, e_dst = 0;
    logic [31:0] e_res = 0, e_opa = 0, e_opb = 0;
    logic e_exc = 0;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            age <= -1; fin <= 0; mdiv <= 0; mrd <= 0;
            e_dst <= 0; e_res <= 0; e_opa <= 0; e_opb <= 0; e_exc <= 0;
        end else if (age < 0) begin
            if (md_f(dx_ir, dx_valid) && !flush) begin
                age <= 1; fin <= 0; mdiv <= dx_ir[6:2] == 5'b00111; mrd <= dx_ir[26:22];
                e_opa <= operand_a; e_opb <= operand_b;
            end
        end else if (age == fin) age <= -1;
        else if (flush) age <= -1;
        else if (age >= 2 && md_result_rdy) begin
            age <= age + 1; fin <= age + 1; e_exc <= md_exception;
            e_dst <= md_exception ? 5'd30 : mrd;
            e_res <= md_exception ? (mdiv ? 32'd5 : 32'd4) : md_result;
        end else if (age >= 2 && age - 2 == T - 1) begin
            age <= age + 1; fin <= age + 1; e_exc <= 1; e_dst <= 5'd30;
            e_res <= mdiv ? 32'd5 : 32'd4;
        end else age <= age + 1;
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("stall", stall, reset && ((age < 0 && md_f(dx_ir, dx_valid) && !flush) || (age >= 1 && age != fin)));
            chk("busy", busy, age >= 1);
            chk("done", done, age >= 1 && age == fin);
            chk("mult_pulse", md_ctrl_mult, age == 1 && !mdiv);
            chk("div_pulse", md_ctrl_div, age == 1 && mdiv);
            chk("op_a", md_operand_a, e_opa);
            chk("op_b", md_operand_b, e_opb);
            chk("result", result, e_res);
            chk("dest_reg", dest_reg, e_dst);
            chk("exception", exception, e_exc);
        end
    end

    task automatic run(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                       input int rdy_c, input logic [31:0] res, input logic exc, input int fl_c,
                       output int done_c, output int stall_n, output int mult_n, output int div_n,
                       output int pulse_c);
        done_c = -1; stall_n = 0; mult_n = 0; div_n = 0; pulse_c = -1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock); #1;
            dx_ir = ir; dx_valid = fl_c < 0 || c <= fl_c; operand_a = a; operand_b = b;
            md_result_rdy = c == rdy_c; md_result = c == rdy_c ? res : 32'hdead_beef;
            md_exception = c == rdy_c && exc; flush = c == fl_c;
            @(negedge clock);
            stall_n += int'(stall); mult_n += int'(md_ctrl_mult); div_n += int'(md_ctrl_div);
            if (md_ctrl_mult || md_ctrl_div) pulse_c = c;
            if (done) begin
                done_c = c;
                break;
            end
            if (fl_c >= 0 && c == fl_c + 3) break;
        end
    endtask

    task automatic idle();
        @(posedge clock); #1;
        dx_valid = 0; md_result_rdy = 0; md_exception = 0; flush = 0;
        @(negedge clock);
    endtask

    int d, s, m, v, p;
    initial begin
        repeat (2) @(posedge clock);
        #1 chk_en = 1;
        @(negedge clock);
        chk("reset stall", stall, 0);
        chk("reset busy", busy, 0);
        chk("reset result", result, 0);
        chk("reset dest", dest_reg, 0);
        @(posedge clock); #1 reset = 1;
        @(negedge clock);

        run(ins(5'b00110, 5'd3), 6, 7, 5, 42, 0, -1, d, s, m, v, p);
        chk("mul done cycle", d, 6);
        chk("mul stall cycles", s, 6);
        chk("mul mult pulses", m, 1);
        chk("mul div pulses", v, 0);
        chk("mul pulse cycle", p, 1);
        chk("mul result", result, 42);
        chk("mul dest", dest_reg, 3);
        chk("mul exc", exception, 0);
        idle();

        run(ins(5'b00111, 5'd4), 9, 0, 3, 32'h1234, 1, -1, d, s, m, v, p);
        chk("div done cycle", d, 4);
        chk("div pulses", v, 1);
        chk("div no mult", m, 0);
        chk("div result", result, 5);
        chk("div dest", dest_reg, 30);
        chk("div exc", exception, 1);
        chk("div op_a", md_operand_a, 9);
        idle();

        run(ins(5'b00110, 5'd6), 11, 12, -1, 0, 0, -1, d, s, m, v, p);
        chk("timeout done cycle", d, 10);
        chk("timeout stall cycles", s, 10);
        chk("timeout result", result, 4);
        chk("timeout dest", dest_reg, 30);
        chk("timeout exc", exception, 1);
        idle();

        run(ins(5'b00110, 5'd7), 2, 3, 4, 6, 0, 3, d, s, m, v, p);
        chk("flush no done", d, -1);
        chk("flush stall cycles", s, 4);
        chk("flush mult pulses", m, 1);
        chk("flush result kept", result, 4);
        chk("flush dest kept", dest_reg, 30);
        idle();

        run(ins(5'b00110, 5'd3), 6, 7, 4, 42, 0, -1, d, s, m, v, p);
        chk("b2b first done", d, 5);
        chk("b2b first result", result, 42);
        run(ins(5'b00110, 5'd5), 3, 5, 4, 15, 0, -1, d, s, m, v, p);
        chk("b2b second done", d, 5);
        chk("b2b second pulse", p, 1);
        chk("b2b second stall", s, 5);
        chk("b2b second result", result, 15);
        chk("b2b second dest", dest_reg, 5);
        idle();

        @(posedge clock); #1;
        dx_ir = ins(5'b00110, 5'd3); dx_valid = 1; operand_a = 6; operand_b = 7;
        repeat (3) begin
            @(posedge clock); #1;
        end
        chk("pre-reset busy", busy, 1);
        chk("pre-reset op_a", md_operand_a, 6);
        reset = 0;
        #1;
        chk("mid reset stall", stall, 0);
        chk("mid reset busy", busy, 0);
        chk("mid reset done", done, 0);
        chk("mid reset result", result, 0);
        @(posedge clock); #1;
        reset = 1; dx_ir = ins(5'b00000, 5'd3);
        @(negedge clock);
        chk("non-md stall", stall, 0);
        @(posedge clock); #1;
        dx_ir = {5'b00001, ins(5'b00110, 5'd3)};
        dx_ir[31:27] = 5'b00001;
        @(negedge clock);
        chk("wrong opcode stall", stall, 0);
        @(posedge clock); #1;
        dx_ir = ins(5'b00111, 5'd3); dx_valid = 0;
        @(negedge clock);
        chk("bubble stall", stall, 0);
        chk("bubble busy", busy, 0);
        @(posedge clock); #1;
        chk_en = 0;
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
